sdram_arb_2port: RTL and testbench
==================================

SDRAM_ARB_2PORT -- requirements
Module: sdram_arb_2port

Interface
REQ-001 SHALL have parameter OUTSTANDING_DEPTH, default 4, giving the maximum number of core-accepted requests awaiting ack; a power of 2, at least 2.
REQ-002 SHALL have port clk_i, in, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, in, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports inport0_wr_i / inport1_wr_i, in, 4, byte-write strobes; any bit set means a write request.
REQ-005 SHALL have ports inport0_rd_i / inport1_rd_i, in, 1, read request.
REQ-006 SHALL have ports inport0_len_i, inport0_addr_i, inport0_write_data_i and the inport1_ equivalents, in, 8/32/32, request fields, held stable until accepted.
REQ-007 SHALL have ports inport0_accept_o / inport1_accept_o, out, 1, request taken this cycle.
REQ-008 SHALL have ports inport0_ack_o / inport1_ack_o, out, 1, response valid.
REQ-009 SHALL have ports inport0_error_o / inport1_error_o, out, 1, response error, qualified by the matching ack.
REQ-010 SHALL have ports inport0_read_data_o / inport1_read_data_o, out, 32, response read data, qualified by the matching ack.
REQ-011 SHALL have ports outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o, outport_write_data_o, out, 4/1/8/32/32, request fields driven to the SDRAM core inport.
REQ-012 SHALL have ports outport_accept_i, outport_ack_i, outport_error_i, outport_read_data_i, in, 1/1/1/32, SDRAM core accept and response.

Function
REQ-013 SHALL implement FSM IDLE -> GRANT -> IDLE.
REQ-014 In IDLE, a port is requesting when (|wr_i | rd_i).
REQ-015 In IDLE, with at least one port requesting and the outstanding FIFO not full, SHALL register the winner into grant_q and enter GRANT on the next edge.
REQ-016 Winner selection SHALL be round-robin: prio_q names the favoured port; a lone requester wins regardless of prio_q.
REQ-017 In IDLE, all outport request outputs SHALL be 0.
REQ-018 In GRANT, outport_* request outputs SHALL be a combinational copy of the inputs of the port named by grant_q.
REQ-019 The granted port's accept_o SHALL equal outport_accept_i; the other port's accept_o SHALL be 0.
REQ-020 In GRANT with outport_accept_i=1, SHALL push grant_q into the FIFO, set prio_q to the other port and return to IDLE.
REQ-021 Minimum latency SHALL be 1 cycle from request to outport request, and 2 cycles between back-to-back accepts.
REQ-022 If the granted port drops its request in GRANT before it is accepted, SHALL return to IDLE without a push and leave prio_q unchanged.
REQ-023 On outport_ack_i=1 with the FIFO non-empty, SHALL pulse ack_o for the port at the FIFO head, pass error/read_data through combinationally and pop the FIFO.
REQ-024 Non-acked ports SHALL drive ack_o=0, error_o=0 and read_data_o=0.
REQ-025 On outport_ack_i=1 with the FIFO empty, SHALL drop the ack (no port acked); the bench asserts on this.
REQ-026 A push and a pop in the same cycle SHALL both occur and leave the count unchanged.
REQ-027 With count==OUTSTANDING_DEPTH, IDLE SHALL not grant; an ack arriving in the same cycle frees the slot from the next cycle.
REQ-028 FIFO pointers SHALL wrap modulo OUTSTANDING_DEPTH; the count SHALL be log2(OUTSTANDING_DEPTH)+1 bits wide.

Reset
REQ-029 On rst_i=1, SHALL set state IDLE, grant_q=0, prio_q=0 and FIFO pointers and count to 0.
REQ-030 During and after reset, all outputs SHALL be 0 until a new grant.
REQ-031 Reset mid-transaction SHALL discard pending responses; core acks arriving later fall under REQ-025.

Structure
REQ-032 Package sdram_arb_pkg SHALL hold the port-id typedef (logic, 0/1), the state enum {ARB_IDLE, ARB_GRANT} and the default depth constant.
REQ-033 The outstanding-id FIFO SHALL be sub-module sdram_arb_id_fifo: synchronous, DEPTH x 1 bit, with push/pop/full/empty/head.

Verification
REQ-034 Port0 alone writes 0xDEADBEEF to 0x100 -> outport_addr_o=0x100 one cycle after request; inport0_accept_o on core accept; inport0_ack_o only.
REQ-035 Both ports request in the same IDLE cycle after reset -> port0 accepted first, port1 next; a repeat of both -> port0 again second (alternates).
REQ-036 Port0 reads 0x200 then port1 reads 0x300, core acks in order with 0x11111111 then 0x22222222 -> port0 receives 0x11111111 and port1 receives 0x22222222.
REQ-037 OUTSTANDING_DEPTH=4, 4 accepts with no ack -> 5th request stalls; ack and request in the same cycle -> grant on the following cycle.
REQ-038 rst_i pulsed with 2 outstanding reads -> the following 2 core acks produce no port ack; a new port1 write completes normally.
REQ-039 Port1 drops rd_i while in GRANT without accept -> returns to IDLE, no FIFO push, prio_q unchanged.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared types and constants for the two-port SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    typedef logic port_id_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int c_DEFAULT_OUTSTANDING_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_id_fifo
// Brief    : DEPTH x 1-bit FIFO of port ids for requests awaiting a core ack.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_OUTSTANDING_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  port_id_t i_data,
    input  logic     i_pop,
    output logic     o_full,
    output logic     o_empty,
    output port_id_t o_head
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    port_id_t           r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arb_2port.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_2port
// Brief    : Round-robin arbiter sharing one SDRAM core port between two masters.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arb_2port
    import sdram_arb_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = c_DEFAULT_OUTSTANDING_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  inport0_wr_i,
    input  logic        inport0_rd_i,
    input  logic [7:0]  inport0_len_i,
    input  logic [31:0] inport0_addr_i,
    input  logic [31:0] inport0_write_data_i,
    output logic        inport0_accept_o,
    output logic        inport0_ack_o,
    output logic        inport0_error_o,
    output logic [31:0] inport0_read_data_o,
    input  logic [3:0]  inport1_wr_i,
    input  logic        inport1_rd_i,
    input  logic [7:0]  inport1_len_i,
    input  logic [31:0] inport1_addr_i,
    input  logic [31:0] inport1_write_data_i,
    output logic        inport1_accept_o,
    output logic        inport1_ack_o,
    output logic        inport1_error_o,
    output logic [31:0] inport1_read_data_o,
    output logic [3:0]  outport_wr_o,
    output logic        outport_rd_o,
    output logic [7:0]  outport_len_o,
    output logic [31:0] outport_addr_o,
    output logic [31:0] outport_write_data_o,
    input  logic        outport_accept_i,
    input  logic        outport_ack_i,
    input  logic        outport_error_i,
    input  logic [31:0] outport_read_data_i
);

    arb_state_t r_state, w_next_state;
    port_id_t   r_grant, w_next_grant;
    port_id_t   r_prio,  w_next_prio;
    logic       w_req0, w_req1, w_sel_req;
    logic       w_push, w_ack_valid;
    logic       w_fifo_full, w_fifo_empty;
    port_id_t   w_fifo_head;

    assign w_req0      = (|inport0_wr_i) | inport0_rd_i;
    assign w_req1      = (|inport1_wr_i) | inport1_rd_i;
    assign w_sel_req   = r_grant ? w_req1 : w_req0;
    assign w_ack_valid = outport_ack_i & ~w_fifo_empty & ~rst_i;

    sdram_arb_id_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  (r_grant),
        .i_pop   (w_ack_valid),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_prio  <= w_next_prio;
        end
    end

    always_comb begin
        w_next_state         = r_state;
        w_next_grant         = r_grant;
        w_next_prio          = r_prio;
        w_push               = 1'b0;
        outport_wr_o         = '0;
        outport_rd_o         = 1'b0;
        outport_len_o        = '0;
        outport_addr_o       = '0;
        outport_write_data_o = '0;
        inport0_accept_o     = 1'b0;
        inport1_accept_o     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if ((w_req0 | w_req1) && !w_fifo_full) begin
                    w_next_state = ARB_GRANT;
                    w_next_grant = (w_req0 && w_req1) ? r_prio : w_req1;
                end
            end
            ARB_GRANT: begin
                if (!rst_i) begin
                    if (r_grant) begin
                        outport_wr_o         = inport1_wr_i;
                        outport_rd_o         = inport1_rd_i;
                        outport_len_o        = inport1_len_i;
                        outport_addr_o       = inport1_addr_i;
                        outport_write_data_o = inport1_write_data_i;
                        inport1_accept_o     = outport_accept_i;
                    end else begin
                        outport_wr_o         = inport0_wr_i;
                        outport_rd_o         = inport0_rd_i;
                        outport_len_o        = inport0_len_i;
                        outport_addr_o       = inport0_addr_i;
                        outport_write_data_o = inport0_write_data_i;
                        inport0_accept_o     = outport_accept_i;
                    end
                end
                // An abandoned request leaves the round-robin pointer untouched
                if (!w_sel_req) begin
                    w_next_state = ARB_IDLE;
                end else if (outport_accept_i) begin
                    w_push       = 1'b1;
                    w_next_prio  = ~r_grant;
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        inport0_ack_o       = 1'b0;
        inport0_error_o     = 1'b0;
        inport0_read_data_o = '0;
        inport1_ack_o       = 1'b0;
        inport1_error_o     = 1'b0;
        inport1_read_data_o = '0;
        if (w_ack_valid) begin
            if (w_fifo_head) begin
                inport1_ack_o       = 1'b1;
                inport1_error_o     = outport_error_i;
                inport1_read_data_o = outport_read_data_i;
            end else begin
                inport0_ack_o       = 1'b1;
                inport0_error_o     = outport_error_i;
                inport0_read_data_o = outport_read_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arb_2port.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arb_2port
// Brief    : Directed scoreboard bench for the two-port SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arb_2port;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  inport0_wr_i, inport1_wr_i;
    logic        inport0_rd_i, inport1_rd_i;
    logic [7:0]  inport0_len_i, inport1_len_i;
    logic [31:0] inport0_addr_i, inport1_addr_i;
    logic [31:0] inport0_write_data_i, inport1_write_data_i;
    logic        inport0_accept_o, inport1_accept_o;
    logic        inport0_ack_o, inport1_ack_o;
    logic        inport0_error_o, inport1_error_o;
    logic [31:0] inport0_read_data_o, inport1_read_data_o;
    logic [3:0]  outport_wr_o;
    logic        outport_rd_o;
    logic [7:0]  outport_len_o;
    logic [31:0] outport_addr_o, outport_write_data_o;
    logic        outport_accept_i, outport_ack_i, outport_error_i;
    logic [31:0] outport_read_data_i;

    typedef struct {
        bit          port;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk_i = ~clk_i;

    sdram_arb_2port #(
        .OUTSTANDING_DEPTH (4)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .inport0_wr_i         (inport0_wr_i),
        .inport0_rd_i         (inport0_rd_i),
        .inport0_len_i        (inport0_len_i),
        .inport0_addr_i       (inport0_addr_i),
        .inport0_write_data_i (inport0_write_data_i),
        .inport0_accept_o     (inport0_accept_o),
        .inport0_ack_o        (inport0_ack_o),
        .inport0_error_o      (inport0_error_o),
        .inport0_read_data_o  (inport0_read_data_o),
        .inport1_wr_i         (inport1_wr_i),
        .inport1_rd_i         (inport1_rd_i),
        .inport1_len_i        (inport1_len_i),
        .inport1_addr_i       (inport1_addr_i),
        .inport1_write_data_i (inport1_write_data_i),
        .inport1_accept_o     (inport1_accept_o),
        .inport1_ack_o        (inport1_ack_o),
        .inport1_error_o      (inport1_error_o),
        .inport1_read_data_o  (inport1_read_data_o),
        .outport_wr_o         (outport_wr_o),
        .outport_rd_o         (outport_rd_o),
        .outport_len_o        (outport_len_o),
        .outport_addr_o       (outport_addr_o),
        .outport_write_data_o (outport_write_data_o),
        .outport_accept_i     (outport_accept_i),
        .outport_ack_i        (outport_ack_i),
        .outport_error_i      (outport_error_i),
        .outport_read_data_i  (outport_read_data_i)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] len_of(input bit p);
        return p ? 8'h1F : 8'h0F;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input bit p, input logic [3:0] wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd);
        if (!p) begin
            inport0_wr_i = wr; inport0_rd_i = rd; inport0_len_i = len_of(p);
            inport0_addr_i = addr; inport0_write_data_i = wd;
        end else begin
            inport1_wr_i = wr; inport1_rd_i = rd; inport1_len_i = len_of(p);
            inport1_addr_i = addr; inport1_write_data_i = wd;
        end
    endtask

    task automatic clr_port(input bit p);
        set_port(p, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk_i);
        check(name, {outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o,
                     outport_write_data_o, inport0_accept_o, inport1_accept_o}, '0);
    endtask

    task automatic check_all_zero(input string name);
        @(negedge clk_i);
        check({name, "_out"}, {outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o,
                               outport_write_data_o, inport0_accept_o, inport1_accept_o}, '0);
        check({name, "_resp"}, {inport0_ack_o, inport1_ack_o, inport0_error_o, inport1_error_o,
                                inport0_read_data_o, inport1_read_data_o}, '0);
    endtask

    task automatic expect_grant(input bit p, input logic [3:0] wr, input logic rd,
                                input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk_i);
        check("grant_accept", {inport0_accept_o, inport1_accept_o}, p ? 2'b01 : 2'b10);
        check("grant_fields", {outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o,
                               outport_write_data_o}, {wr, rd, len_of(p), addr, wd});
    endtask

    // One-cycle core response; an unexpected one must not reach either port
    task automatic core_ack(input logic [31:0] d, input logic e, input bit expected, input bit p);
        outport_ack_i = 1'b1; outport_read_data_i = d; outport_error_i = e;
        if (expected) exp_q.push_back('{port: p, err: e, data: d});
        @(negedge clk_i);
        if (!expected) check("dropped_ack", {inport0_ack_o, inport1_ack_o}, 2'b00);
        tick();
        outport_ack_i = 1'b0; outport_read_data_i = '0; outport_error_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (inport0_ack_o || inport1_ack_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=%b%b required=none", inport0_ack_o, inport1_ack_o);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("resp_port", {inport0_ack_o, inport1_ack_o}, r.port ? 2'b01 : 2'b10);
                if (r.port) begin
                    check("resp_data", {inport1_error_o, inport1_read_data_o}, {r.err, r.data});
                    check("resp_other", {inport0_error_o, inport0_read_data_o}, '0);
                end else begin
                    check("resp_data", {inport0_error_o, inport0_read_data_o}, {r.err, r.data});
                    check("resp_other", {inport1_error_o, inport1_read_data_o}, '0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        clr_port(1'b0);
        clr_port(1'b1);
        outport_accept_i = 1'b1;
        outport_ack_i = 1'b0; outport_error_i = 1'b0; outport_read_data_i = '0;
        repeat (3) tick();
        check_all_zero("reset");
        tick();
        rst_i = 1'b0;
        check_all_zero("post_reset");

        // Both request after reset: port0 first, then port1
        tick();
        set_port(1'b0, 4'hF, 1'b0, 32'h10, 32'hA0A0A0A0);
        set_port(1'b1, 4'h3, 1'b0, 32'h20, 32'hB1B1B1B1);
        check_idle("rr_idle");
        tick(); expect_grant(1'b0, 4'hF, 1'b0, 32'h10, 32'hA0A0A0A0);
        tick(); clr_port(1'b0); check_idle("b2b_gap");
        tick(); expect_grant(1'b1, 4'h3, 1'b0, 32'h20, 32'hB1B1B1B1);
        tick(); clr_port(1'b1);
        core_ack(32'h5555AAAA, 1'b0, 1'b1, 1'b0);
        core_ack(32'hCAFE0001, 1'b1, 1'b1, 1'b1);

        // Lone port0 write
        set_port(1'b0, 4'hF, 1'b0, 32'h100, 32'hDEADBEEF);
        check_idle("single_idle");
        tick(); expect_grant(1'b0, 4'hF, 1'b0, 32'h100, 32'hDEADBEEF);
        tick(); clr_port(1'b0);
        core_ack(32'h0, 1'b0, 1'b1, 1'b0);

        // Port0 was last served, so port1 now wins a tie
        set_port(1'b0, 4'h2, 1'b0, 32'h30, 32'h30303030);
        set_port(1'b1, 4'h8, 1'b0, 32'h40, 32'h40404040);
        check_idle("rr2_idle");
        tick(); expect_grant(1'b1, 4'h8, 1'b0, 32'h40, 32'h40404040);
        tick(); clr_port(1'b1); check_idle("rr2_gap");
        tick(); expect_grant(1'b0, 4'h2, 1'b0, 32'h30, 32'h30303030);
        tick(); clr_port(1'b0);
        core_ack(32'h0000B001, 1'b0, 1'b1, 1'b1);
        core_ack(32'h0000B000, 1'b0, 1'b1, 1'b0);

        // In-order read returns
        set_port(1'b0, 4'h0, 1'b1, 32'h200, 32'h0);
        check_idle("rd0_idle");
        tick(); expect_grant(1'b0, 4'h0, 1'b1, 32'h200, 32'h0);
        tick(); clr_port(1'b0); set_port(1'b1, 4'h0, 1'b1, 32'h300, 32'h0);
        check_idle("rd1_idle");
        tick(); expect_grant(1'b1, 4'h0, 1'b1, 32'h300, 32'h0);
        tick(); clr_port(1'b1);
        core_ack(32'h11111111, 1'b0, 1'b1, 1'b0);
        core_ack(32'h22222222, 1'b0, 1'b1, 1'b1);

        // Fill all 4 outstanding slots; 5th request must stall
        set_port(1'b0, 4'hF, 1'b0, 32'h400, 32'h44444444);
        @(negedge clk_i);
        check("full_seq", inport0_accept_o, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            @(negedge clk_i);
            check("full_seq", inport0_accept_o, (i == 1 || i == 3 || i == 5 || i == 7));
        end
        tick();
        outport_ack_i = 1'b1; outport_read_data_i = 32'h33333333;
        exp_q.push_back('{port: 1'b0, err: 1'b0, data: 32'h33333333});
        @(negedge clk_i);
        check("full_ack_cycle", {outport_wr_o, inport0_accept_o}, '0);
        tick();
        outport_ack_i = 1'b0; outport_read_data_i = '0;
        check_idle("full_release_idle");
        tick(); expect_grant(1'b0, 4'hF, 1'b0, 32'h400, 32'h44444444);
        tick(); clr_port(1'b0);
        for (int i = 0; i < 4; i++) core_ack(32'h40000000 + i, 1'b0, 1'b1, 1'b0);

        // Port1 abandons its grant: no push, pointer still favours port1
        outport_accept_i = 1'b0;
        set_port(1'b1, 4'h0, 1'b1, 32'h500, 32'h0);
        check_idle("drop_idle");
        tick(); @(negedge clk_i);
        check("drop_granted", {outport_rd_o, outport_addr_o, inport1_accept_o}, {1'b1, 32'h500, 1'b0});
        tick(); clr_port(1'b1); @(negedge clk_i);
        check("drop_follow", {outport_wr_o, outport_rd_o, inport1_accept_o}, '0);
        tick();
        outport_accept_i = 1'b1;
        set_port(1'b0, 4'h1, 1'b0, 32'h510, 32'h51515151);
        set_port(1'b1, 4'h4, 1'b0, 32'h520, 32'h52525252);
        check_idle("drop_rr_idle");
        tick(); expect_grant(1'b1, 4'h4, 1'b0, 32'h520, 32'h52525252);
        tick(); clr_port(1'b1); check_idle("drop_rr_gap");
        tick(); expect_grant(1'b0, 4'h1, 1'b0, 32'h510, 32'h51515151);
        tick(); clr_port(1'b0);
        core_ack(32'h0000C001, 1'b0, 1'b1, 1'b1);
        core_ack(32'h0000C000, 1'b0, 1'b1, 1'b0);

        // Reset with two reads outstanding discards their responses
        set_port(1'b0, 4'h0, 1'b1, 32'h600, 32'h0);
        check_idle("rst_rd0_idle");
        tick(); expect_grant(1'b0, 4'h0, 1'b1, 32'h600, 32'h0);
        tick(); clr_port(1'b0); set_port(1'b1, 4'h0, 1'b1, 32'h700, 32'h0);
        check_idle("rst_rd1_idle");
        tick(); expect_grant(1'b1, 4'h0, 1'b1, 32'h700, 32'h0);
        tick(); clr_port(1'b1);
        rst_i = 1'b1;
        outport_ack_i = 1'b1; outport_read_data_i = 32'h99999999;
        check_all_zero("mid_reset");
        tick();
        rst_i = 1'b0;
        outport_ack_i = 1'b0; outport_read_data_i = '0;
        core_ack(32'hAAAA0001, 1'b0, 1'b0, 1'b0);
        core_ack(32'hAAAA0002, 1'b0, 1'b0, 1'b0);
        set_port(1'b1, 4'h1, 1'b0, 32'h800, 32'h12345678);
        check_idle("post_rst_idle");
        tick(); expect_grant(1'b1, 4'h1, 1'b0, 32'h800, 32'h12345678);
        tick(); clr_port(1'b1);
        core_ack(32'h5A5A5A5A, 1'b0, 1'b1, 1'b1);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
